ws2812_bit_encoder: RTL and testbench

- Consumer side of the LED timing config registers.
- Takes a byte stream of pixel data through a valid/ready handshake and serialises it MSB-first into the WS2812 single-wire waveform.
- Uses the programmed high/low counts for 1 and 0 bits and the reset-gap count.
- Sits between the layer frame buffer reader and the LED data pin.

---
 rtl/ws2812_bit_encoder.sv | 160 ++++++++++++++++
 tb/tb_ws2812_bit_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire serialiser: bytes arrive on a valid/ready port and leave MSB-first
// as high/low pulse pairs, with a reset gap and done pulse after the last byte of a frame.
module ws2812_bit_encoder #(
    parameter int RST_UNIT = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] rst_cnt_in,
    input  logic [7:0] t1_h_cnt_in,
    input  logic [7:0] t1_l_cnt_in,
    input  logic [7:0] t0_h_cnt_in,
    input  logic [7:0] t0_l_cnt_in,
    input  logic [7:0] data_in,
    input  logic       data_last_in,
    input  logic       data_valid_in,
    output logic       data_ready_out,
    output logic       bit_code_out,
    output logic       busy_out,
    output logic       underrun_out,
    output logic       done_out,
    output logic [2:0] state_dbg_out
);

    localparam int LOG = $clog2(RST_UNIT);
    localparam int RW  = 8 + LOG;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIT_H = 3'd1,
        BIT_L = 3'd2,
        WAIT  = 3'd3,
        RST   = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [7:0]    hold_data;
    logic          hold_last, hold_full;
    logic [6:0]    shift_data;
    logic          shift_last;
    logic [2:0]    idx;
    logic [7:0]    cnt, l_m1;
    logic [RW-1:0] rcnt;

    logic          accept, bit_end, rst_end, next_bit, reload, enter_h, new_bit;
    logic [7:0]    sel_h, sel_l, h_eff, l_eff, rst_eff;
    logic [RW-1:0] rst_load;
    logic          bit_code_d, underrun_d, done_d;

    // Handshake: a byte moves into hold on an edge where data_valid_in && data_ready_out.
    // data_ready_out is !hold_full from a register, so fill and drain never share an edge.
    assign data_ready_out = !hold_full;
    assign busy_out       = (state != IDLE) || hold_full;
    assign state_dbg_out  = state;

    always_comb begin
        accept   = data_valid_in && !hold_full;
        bit_end  = (state == BIT_L) && (cnt == 8'd0);
        rst_end  = (state == RST) && (rcnt == '0);
        next_bit = bit_end && (idx != 3'd0);
        reload   = hold_full && ((state == IDLE) || (state == WAIT) ||
                   (bit_end && (idx == 3'd0) && !shift_last));
        enter_h  = reload || next_bit;
        // The bit about to start comes from hold on a reload, else from the shifter.
        new_bit  = reload ? hold_data[7] : shift_data[6];
        sel_h    = new_bit ? t1_h_cnt_in : t0_h_cnt_in;
        sel_l    = new_bit ? t1_l_cnt_in : t0_l_cnt_in;
        h_eff    = (sel_h == 8'd0) ? 8'd1 : sel_h;
        l_eff    = (sel_l == 8'd0) ? 8'd1 : sel_l;
        rst_eff  = (rst_cnt_in == 8'd0) ? 8'd1 : rst_cnt_in;
        rst_load = (RW'(rst_eff) << LOG) - RW'(1);
    end

    // State register plus registered outputs (all outputs lag the state by one edge).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            bit_code_out <= 1'b0;
            underrun_out <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            state        <= next_state;
            bit_code_out <= bit_code_d;
            underrun_out <= underrun_d;
            done_out     <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (hold_full) next_state = BIT_H;
            BIT_H: if (cnt == 8'd0) next_state = BIT_L;
            BIT_L: begin
                if (cnt == 8'd0) begin
                    if (idx != 3'd0)    next_state = BIT_H;
                    else if (shift_last) next_state = RST;
                    else if (hold_full)  next_state = BIT_H;
                    else                 next_state = WAIT;
                end
            end
            WAIT:  if (hold_full) next_state = BIT_H;
            RST:   if (rcnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bit_code_d = (state == BIT_H);
        underrun_d = bit_end && (idx == 3'd0) && !shift_last && !hold_full;
        done_d     = rst_end;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_data  <= 8'd0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            shift_data <= 7'd0;
            shift_last <= 1'b0;
            idx        <= 3'd0;
            cnt        <= 8'd0;
            l_m1       <= 8'd0;
            rcnt       <= '0;
        end else begin
            if (accept) begin
                hold_data <= data_in;
                hold_last <= data_last_in;
                hold_full <= 1'b1;
            end else if (reload) begin
                hold_full <= 1'b0;
            end

            if (reload) begin
                shift_data <= hold_data[6:0];
                shift_last <= hold_last;
                idx        <= 3'd7;
            end else if (next_bit) begin
                shift_data <= {shift_data[5:0], 1'b0};
                idx        <= idx - 3'd1;
            end

            // Timing is captured at bit start so count changes never disturb a running bit.
            if (enter_h) begin
                cnt  <= h_eff - 8'd1;
                l_m1 <= l_eff - 8'd1;
            end else if (state == BIT_H) begin
                cnt <= (cnt == 8'd0) ? l_m1 : cnt - 8'd1;
            end else if ((state == BIT_L) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end

            if (bit_end && (idx == 3'd0) && shift_last) begin
                rcnt <= rst_load;
            end else if ((state == RST) && (rcnt != '0)) begin
                rcnt <= rcnt - RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Directed bench for ws2812_bit_encoder: single-byte frame table, then gapless stream,
// underrun/resume, mid-bit count change and mid-frame reset sequences.
module tb_ws2812_bit_encoder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] rst_cnt_in, t1_h_cnt_in, t1_l_cnt_in, t0_h_cnt_in, t0_l_cnt_in;
    logic [7:0] data_in;
    logic       data_last_in, data_valid_in;
    logic       data_ready_out, bit_code_out, busy_out, underrun_out, done_out;
    logic [2:0] state_dbg_out;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];  // per-cycle {done_out, bit_code_out}

    typedef struct {
        logic [7:0] t1h, t1l, t0h, t0l, rst, data;
        int exp_hi, exp_len, exp_gap;
    } vec_t;
    vec_t vecs[6];

    ws2812_bit_encoder #(.RST_UNIT(64)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rst_cnt_in(rst_cnt_in),
        .t1_h_cnt_in(t1_h_cnt_in), .t1_l_cnt_in(t1_l_cnt_in),
        .t0_h_cnt_in(t0_h_cnt_in), .t0_l_cnt_in(t0_l_cnt_in),
        .data_in(data_in), .data_last_in(data_last_in), .data_valid_in(data_valid_in),
        .data_ready_out(data_ready_out), .bit_code_out(bit_code_out), .busy_out(busy_out),
        .underrun_out(underrun_out), .done_out(done_out), .state_dbg_out(state_dbg_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] a, b, c, d, r);
        t1_h_cnt_in = a; t1_l_cnt_in = b; t0_h_cnt_in = c; t0_l_cnt_in = d; rst_cnt_in = r;
    endtask

    task automatic push_bit(input int h, input int l);
        repeat (h) exp_q.push_back(2'b01);
        repeat (l) exp_q.push_back(2'b00);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int h, l;
        for (int i = 7; i >= 0; i--) begin
            h = b[i] ? int'(t1_h_cnt_in) : int'(t0_h_cnt_in);
            l = b[i] ? int'(t1_l_cnt_in) : int'(t0_l_cnt_in);
            push_bit((h == 0) ? 1 : h, (l == 0) ? 1 : l);
        end
    endtask

    task automatic push_gap(input int r);
        repeat (((r == 0) ? 1 : r) * 64 - 1) exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send(input logic [7:0] b, input logic last, output int w);
        data_in = b; data_last_in = last; data_valid_in = 1'b1; w = 0;
        while (!data_ready_out && w < 3000) begin
            @(negedge clk_in); w++;
        end
        if (w >= 3000) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=%0d expected<3000", w);
        end
        @(negedge clk_in);
        data_valid_in = 1'b0;
    endtask

    task automatic wait_rise(output int k);
        k = 0;
        while (!bit_code_out && k < 500) begin
            @(negedge clk_in); k++;
        end
    endtask

    // Scoreboard: compare one sample per cycle against exp_q, starting at the current negedge.
    task automatic run_stream(input int chg_at, output int mism, output int hi, output int n,
                              output int und_n, output int und_idx, output int done_n);
        logic [1:0] e;
        mism = 0; hi = 0; n = 0; und_n = 0; und_idx = 0; done_n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n++;
            if ({done_out, bit_code_out} != e) mism++;
            if (bit_code_out) hi++;
            if (done_out) done_n++;
            if (underrun_out) begin und_n++; und_idx = n; end
            if (n == chg_at) t1_h_cnt_in = 8'd10;
            if (exp_q.size() > 0) @(negedge clk_in);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int w, k, mism, hi, n, und_n, und_idx, done_n;
        set_cfg(v.t1h, v.t1l, v.t0h, v.t0l, v.rst);
        exp_q.delete();
        push_byte(v.data);
        push_gap(int'(v.rst));
        send(v.data, 1'b1, w);
        wait_rise(k);
        check("rise_latency", k, 2);
        check("busy_at_rise", busy_out, 1);
        run_stream(-1, mism, hi, n, und_n, und_idx, done_n);
        check("frame_wave", mism, 0);
        check("frame_high_cycles", hi, v.exp_hi);
        check("frame_total_cycles", n, v.exp_len + v.exp_gap);
        check("frame_underrun", und_n, 0);
        check("frame_done", done_n, 1);
        check("idle_busy", busy_out, 0);
        check("idle_ready", data_ready_out, 1);
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        int w, k, mism, hi, n, und_n, und_idx, done_n, viol;

        vecs[0] = '{8'd4, 8'd2, 8'd2, 8'd4, 8'd1, 8'hA5, 24, 48, 64};
        vecs[1] = '{8'd3, 8'd1, 8'd1, 8'd3, 8'd2, 8'hF0, 16, 32, 128};
        vecs[2] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h3C, 8, 16, 64};
        vecs[3] = '{8'd4, 8'd2, 8'd0, 8'd0, 8'd0, 8'h00, 8, 16, 64};
        vecs[4] = '{8'd5, 8'd7, 8'd2, 8'd9, 8'd3, 8'h81, 22, 90, 192};
        vecs[5] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'hFF, 8, 16, 64};

        // Clock/reset
        rst_in = 1'b1; data_in = 8'd0; data_last_in = 1'b0; data_valid_in = 1'b0;
        set_cfg(8'd4, 8'd2, 8'd2, 8'd4, 8'd1);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_bit", bit_code_out, 0);
        check("rst_ready", data_ready_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_underrun", underrun_out, 0);
        check("rst_done", done_out, 0);
        check("rst_state", state_dbg_out, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Gapless three-byte frame with valid held
        set_cfg(8'd4, 8'd2, 8'd2, 8'd4, 8'd1);
        exp_q.delete();
        push_byte(8'hFF); push_byte(8'h00); push_byte(8'h81); push_gap(1);
        fork
            begin
                int ws;
                send(8'hFF, 1'b0, ws);
                check("gapless_ready_drop", data_ready_out, 0);
                send(8'h00, 1'b0, ws);
                check("gapless_ready_gap", ws, 1);
                send(8'h81, 1'b1, ws);
            end
            begin
                int kk;
                wait_rise(kk);
                run_stream(-1, mism, hi, n, und_n, und_idx, done_n);
            end
        join
        check("gapless_wave", mism, 0);
        check("gapless_high_cycles", hi, 68);
        check("gapless_total", n, 144 + 64);
        check("gapless_underrun", und_n, 0);
        check("gapless_done", done_n, 1);
        repeat (3) @(negedge clk_in);

        // Underrun then resume after WAIT
        exp_q.delete();
        push_byte(8'h00);
        send(8'h00, 1'b0, w);
        wait_rise(k);
        check("underrun_rise", k, 2);
        run_stream(-1, mism, hi, n, und_n, und_idx, done_n);
        check("underrun_wave", mism, 0);
        check("underrun_count", und_n, 1);
        check("underrun_at_bit0_end", und_idx, 48);
        check("underrun_no_done", done_n, 0);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bit_code_out || underrun_out || done_out) viol++;
        end
        check("wait_low", viol, 0);
        check("wait_busy", busy_out, 1);
        exp_q.delete();
        push_byte(8'h80); push_gap(1);
        send(8'h80, 1'b1, w);
        wait_rise(k);
        check("wait_resume_rise", k, 2);
        run_stream(-1, mism, hi, n, und_n, und_idx, done_n);
        check("resume_wave", mism, 0);
        check("resume_underrun", und_n, 0);
        check("resume_done", done_n, 1);
        repeat (3) @(negedge clk_in);

        // t1_h changed during the first high phase: only later bits see it
        set_cfg(8'd4, 8'd2, 8'd2, 8'd4, 8'd1);
        exp_q.delete();
        push_bit(4, 2);
        repeat (7) push_bit(10, 2);
        push_gap(1);
        send(8'hFF, 1'b1, w);
        wait_rise(k);
        run_stream(2, mism, hi, n, und_n, und_idx, done_n);
        check("cfg_change_wave", mism, 0);
        check("cfg_change_high", hi, 74);
        t1_h_cnt_in = 8'd4;
        repeat (3) @(negedge clk_in);

        // Reset in bit 3 with hold full
        send(8'hFF, 1'b0, w);
        send(8'h55, 1'b0, w);
        repeat (25) @(negedge clk_in);
        check("prerst_busy", busy_out, 1);
        check("prerst_ready", data_ready_out, 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("midrst_bit", bit_code_out, 0);
        check("midrst_ready", data_ready_out, 1);
        check("midrst_busy", busy_out, 0);
        check("midrst_done", done_out, 0);
        check("midrst_state", state_dbg_out, 0);
        rst_in = 1'b0;
        viol = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_in);
            if (bit_code_out || done_out || busy_out) viol++;
        end
        check("postrst_quiet", viol, 0);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
